multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control unit for the 16-bit datapath. It is the issuing end of the ALU's 3-bit `control` interface. It sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath mux select and write enable. It also decodes the 4-bit opcode into the ALU operation code that the ALU consumes.

## Interface
Parameters:
- `PC_INC`, default 2: byte increment applied to PC in FETCH; selected by `alu_src_b = 01`.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous and active-high.
- `opcode`, in, 4: IR[15:12]; valid from DECODE onward.
- `zero`, in, 1: ALU zero flag; sampled combinationally in BRANCH.
- `pc_write`, out, 1: PC load enable.
- `iord`, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, out, 1: memory read strobe.
- `mem_write`, out, 1: memory write strobe.
- `ir_write`, out, 1: instruction register load.
- `reg_write`, out, 1: register file write enable.
- `mem_to_reg`, out, 1: writeback source; 0 = ALUOut, 1 = MDR.
- `reg_dst`, out, 1: destination field; 0 = rt, 1 = rd.
- `alu_src_a`, out, 1: ALU operand A; 0 = PC, 1 = A.
- `alu_src_b`, out, 2: ALU operand B; 00 = B, 01 = PC_INC, 10 = sign-extended imm, 11 = sign-extended imm << 1.
- `alu_control`, out, 3: ALU op; 0 and, 1 or, 2 add, 3 sub, 4 sl, 5 sr, 6 slt, 7 never driven.
- `pc_source`, out, 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted`, out, 1: high in HALT.
- `state`, out, 4: current state, for debug.

## Operation
- Opcodes:
  - 0–6: R-type. The ALU op equals the opcode.
  - 7 addi, 8 lw, 9 sw, A beq, B j.
  - C–F: illegal.
- Outputs are Moore, a pure function of `state`. The one exception is `pc_write` in BRANCH, which equals `zero`.
- Any output not listed for a state is 0. `alu_control` defaults to 2 (add).
- States (4-bit encoding) and the outputs each asserts:
  - FETCH=0: mem_read, ir_write, pc_write, src_a=0, src_b=01, add, pc_source=00. Next: DECODE.
  - DECODE=1: src_a=0, src_b=11, add (branch target into ALUOut).
    - Next: EXEC_R for op 0–6, EXEC_I for 7, MEM_ADDR for 8/9, BRANCH for A, JUMP for B, HALT for C–F.
  - EXEC_R=2: src_a=1, src_b=00, alu_control=opcode. Next: R_WB.
  - R_WB=3: reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - EXEC_I=4: src_a=1, src_b=10, add. Next: I_WB.
  - I_WB=5: reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - MEM_ADDR=6: src_a=1, src_b=10, add. Next: MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ=7: mem_read, iord=1. Next: MEM_WB.
  - MEM_WB=8: reg_write, reg_dst=0, mem_to_reg=1. Next: FETCH.
  - MEM_WRITE=9: mem_write, iord=1. Next: FETCH.
  - BRANCH=10: src_a=1, src_b=00, sub, pc_source=01, pc_write=zero. Next: FETCH.
  - JUMP=11: pc_write, pc_source=10. Next: FETCH.
  - HALT=12: halted=1; no writes. Remains in HALT until reset.
- Unused encodings 13–15 return to FETCH on the next edge and assert no enables.
- The opcode is read only in DECODE, EXEC_R and MEM_ADDR. IR is stable because `ir_write` is asserted only in FETCH.

## Timing
- Reset:
  - While `reset` = 1, the state register loads FETCH at every edge.
  - While `reset` = 1, all enables (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0, and `halted` = 0.
  - Mux selects are not gated by reset; they show FETCH values.
  - The first FETCH cycle with enables active is the first cycle in which `reset` = 0.
- Reset asserted mid-instruction aborts that instruction at the next edge. No partial write occurs after that edge.
- Cycles per instruction, FETCH inclusive:
  - R-type, addi, sw: 4.
  - lw: 5.
  - beq, j: 3.
- The write in R_WB / I_WB / MEM_WB and the PC update in BRANCH / JUMP commit at the edge that leaves the state. FETCH follows in the same cycle.
- BRANCH with `zero` toggling within the cycle: only the value at the rising edge matters.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode constants;
  - ALU control codes 0–6 (shared with the ALU);
  - state encodings;
  - `alu_src_b` and `pc_source` select codes.
- Sub-module `alu_op_decode`: combinational mapping of (state class, opcode) to `alu_control`.
  - R-type passes the opcode through.
  - BRANCH gives sub; every other state gives add.
- The top level contains the state register, the next-state logic and the output decode.

## Test plan
- Reset held for 3 cycles, then released with opcode=2:
  - during reset, all enables are 0 and state=0;
  - after release, the sequence is FETCH, DECODE, EXEC_R (alu_control=2), R_WB (reg_write=1, reg_dst=1), FETCH.
- Opcode sweep 0–6: EXEC_R shows alu_control equal to the opcode; each instruction takes 4 cycles.
- lw (8) then sw (9):
  - lw visits states 0, 1, 6, 7, 8, with mem_read=1 and iord=1 in state 7;
  - sw visits states 0, 1, 6, 9, with mem_write=1 in state 9.
- beq (A):
  - with zero=1, pc_write=1 and pc_source=01 in state 10;
  - with zero=0, pc_write=0;
  - both cases return to FETCH after 3 cycles.
- Opcode E: enters HALT; halted=1 and all enables stay 0 for 20 cycles; reset returns the unit to FETCH.
- Reset asserted during MEM_READ of lw: at the next edge state=FETCH, and reg_write is never asserted for that lw.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the multi-cycle control unit.
// Holds the opcode map, the ALU control codes (also consumed by the ALU),
// the controller state encodings and the datapath mux select codes.
package cpu_ctrl_pkg;

  // Opcodes (IR[15:12]). 0..OP_RMAX are R-type, C..F are illegal.
  localparam logic [3:0] OP_RMAX = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_J    = 4'hB;

  // ALU control codes; 7 is never issued.
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SL  = 3'd4;
  localparam logic [2:0] ALU_SR  = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_RMAX;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU operation select.
// Ports:
//   exec_r      in  1 : controller is in the R-type execute state
//   branch      in  1 : controller is in the branch compare state
//   opcode      in  4 : IR[15:12]
//   alu_control out 3 : ALU op (opcode for R-type, sub for branch, else add)
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       exec_r,
  input  logic       branch,
  input  logic [3:0] opcode,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    // is_rtype guard keeps code 7 from ever leaking out of a stray opcode
    if (exec_r && is_rtype(opcode)) alu_control = opcode[2:0];
    else if (branch)                alu_control = ALU_SUB;
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM controller for the 16-bit datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath
// selects and write enables (Moore, except pc_write = zero in BRANCH).
// Ports:
//   clock, reset (sync, active-high)
//   opcode[3:0], zero               : from IR and ALU
//   pc_write, iord, mem_read, mem_write, ir_write, reg_write,
//   mem_to_reg, reg_dst, alu_src_a, alu_src_b[1:0], alu_control[2:0],
//   pc_source[1:0]                  : datapath control
//   halted, state[3:0]              : status / debug
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_INC = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [3:0] state
);

  // PC_INC is applied by the datapath on the SRCB_INC leg; it only has to be
  // a meaningful byte step here.
  if (PC_INC <= 0) begin : g_pc_inc_invalid
  end

  state_e state_q, state_d, dec_st;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_rtype(opcode)) state_d = S_EXEC_R;
        else begin
          case (opcode)
            OP_ADDI:      state_d = S_EXEC_I;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_HALT;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH; // writebacks, branch, jump, 13-15
    endcase
  end

  // While reset is held the selects show FETCH values regardless of the
  // stale state, and the enables are zeroed below.
  assign dec_st = reset ? S_FETCH : state_q;
  assign state  = state_q;

  alu_op_decode u_alu_op (
    .exec_r      (dec_st == S_EXEC_R),
    .branch      (dec_st == S_BRANCH),
    .opcode      (opcode),
    .alu_control (alu_control)
  );

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    halted     = 1'b0;
    case (dec_st)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_INC;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH; // branch target into ALUOut
      S_EXEC_R:   alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule
